// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants for the inst/data SRAM-port arbiter: source tags, FSM states, size codes.
package sram_arb_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// One SRAM-like request/response port; master issues requests, slave answers.
interface sram_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, size, wstrb, addr, wdata,
                    output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_req_arbiter_tag_fifo.sv
// 1-bit source-tag FIFO; push visible at head next cycle; push at full only with a same-cycle pop.
module arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_dat,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [DEPTH-1:0] store;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = store[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/sram_req_arbiter.sv
// Two-master SRAM port arbiter: data wins unless inst has starved; zero-latency grant.
// Unaccepted requests lock the source until mem_addr_ok; responses routed by in-order tag FIFO.
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_OUTST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_req_arbiter_if.slave    inst,
    sram_req_arbiter_if.slave    data,
    sram_req_arbiter_if.master   mem
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t        state, state_nxt;
    logic              src_sel;
    logic              req_c;
    logic              accept;
    logic              pop;
    logic              fifo_full, fifo_empty, fifo_head;
    logic [SW-1:0]     starve_cnt;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic [DATA_W-1:0] rdata_buf;

    always_comb begin
        src_sel   = SRC_INST;
        req_c     = 1'b0;
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (!fifo_full) begin
                    if (data.req && !((starve_cnt == STARVE_MAX) && inst.req)) begin
                        src_sel = SRC_DATA;
                        req_c   = 1'b1;
                    end else if (inst.req) begin
                        src_sel = SRC_INST;
                        req_c   = 1'b1;
                    end
                end
            end
            HOLD_I: begin
                src_sel = SRC_INST;
                req_c   = 1'b1;
            end
            HOLD_D: begin
                src_sel = SRC_DATA;
                req_c   = 1'b1;
            end
            default: ;
        endcase
        if (req_c && !mem.addr_ok)
            state_nxt = (src_sel == SRC_DATA) ? HOLD_D : HOLD_I;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign addr_mux  = (src_sel == SRC_DATA) ? data.addr  : inst.addr;
    assign wdata_mux = (src_sel == SRC_DATA) ? data.wdata : inst.wdata;
    assign mem.req   = req_c;
    assign mem.wr    = (src_sel == SRC_DATA) ? data.wr    : inst.wr;
    assign mem.size  = (src_sel == SRC_DATA) ? data.size  : inst.size;
    assign mem.wstrb = (src_sel == SRC_DATA) ? data.wstrb : inst.wstrb;
    assign mem.addr  = addr_mux;
    assign mem.wdata = wdata_mux;

    assign accept       = req_c & mem.addr_ok;
    assign inst.addr_ok = accept & (src_sel == SRC_INST);
    assign data.addr_ok = accept & (src_sel == SRC_DATA);

    // Response goes to whichever master owns the oldest outstanding request.
    assign pop          = mem.data_ok & ~fifo_empty;
    assign inst.data_ok = pop & (fifo_head == SRC_INST);
    assign data.data_ok = pop & (fifo_head == SRC_DATA);
    assign rdata_buf    = mem.rdata;
    assign inst.rdata   = rdata_buf;
    assign data.rdata   = rdata_buf;

    arb_tag_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_dat (src_sel),
        .pop      (mem.data_ok),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (!inst.req || inst.addr_ok)
            starve_cnt <= '0;
        else if (data.addr_ok && (starve_cnt != STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end

    a_resp_with_outstanding: assert property (@(posedge clk) disable iff (reset)
        mem.data_ok |-> !fifo_empty);
    a_hold_i_req_kept: assert property (@(posedge clk) disable iff (reset)
        (state == HOLD_I) |-> inst.req);
    a_hold_d_req_kept: assert property (@(posedge clk) disable iff (reset)
        (state == HOLD_D) |-> data.req);
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: vector table, directed corner sequences, randomized run vs queue model.
module tb_sram_req_arbiter;
    import sram_arb_pkg::*;

    localparam int MAXO  = 4;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    sram_req_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(MAXO), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_if),
        .data  (data_if),
        .mem   (mem_if)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic drive_inst(input logic r, input logic [31:0] a);
        inst_if.req = r; inst_if.addr = a; inst_if.wr = 1'b0;
        inst_if.size = SIZE_WORD; inst_if.wstrb = 4'hf; inst_if.wdata = '0;
    endtask

    task automatic drive_data(input logic r, input logic [31:0] a);
        data_if.req = r; data_if.addr = a; data_if.wr = 1'b0;
        data_if.size = SIZE_WORD; data_if.wstrb = 4'hf; data_if.wdata = '0;
    endtask

    task automatic drive_mem(input logic aok, input logic dok, input logic [31:0] rd);
        mem_if.addr_ok = aok; mem_if.data_ok = dok; mem_if.rdata = rd;
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive_inst(1'b0, '0); drive_data(1'b0, '0); drive_mem(1'b0, 1'b0, '0);
        reset = 1'b1;
        next_cyc(); next_cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        ireq, dreq, aok;
        logic        ereq, eiok, edok;
        logic [31:0] eaddr;
    } vec_t;
    vec_t vecs[6];

    logic [31:0] resp[4];
    int          tags[4];
    int          found;

    // Reference model state for the random phase
    int          q[$];
    int          lock;
    int          starve;
    logic        exp_req, acc, pop;
    int          exp_sel;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2000};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2000};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2000};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000};

        do_reset();
        @(negedge clk);
        check("rst_mem_req", mem_if.req, 1'b0);
        check("rst_inst_addr_ok", inst_if.addr_ok, 1'b0);
        check("rst_data_addr_ok", data_if.addr_ok, 1'b0);
        check("rst_inst_data_ok", inst_if.data_ok, 1'b0);
        check("rst_data_data_ok", data_if.data_ok, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            drive_inst(vecs[i].ireq, 32'h1000);
            drive_data(vecs[i].dreq, 32'h2000);
            drive_mem(vecs[i].aok, 1'b0, '0);
            @(negedge clk);
            check($sformatf("vec%0d_mem_req", i), mem_if.req, vecs[i].ereq);
            check($sformatf("vec%0d_inst_addr_ok", i), inst_if.addr_ok, vecs[i].eiok);
            check($sformatf("vec%0d_data_addr_ok", i), data_if.addr_ok, vecs[i].edok);
            if (vecs[i].ereq) check($sformatf("vec%0d_mem_addr", i), mem_if.addr, vecs[i].eaddr);
            next_cyc();
        end

        // Both request together: data first, inst next, responses return in that order
        do_reset();
        drive_inst(1'b1, 32'h1000); drive_data(1'b1, 32'h2000); drive_mem(1'b1, 1'b0, '0);
        @(negedge clk);
        check("both_c0_data_addr_ok", data_if.addr_ok, 1'b1);
        check("both_c0_inst_addr_ok", inst_if.addr_ok, 1'b0);
        next_cyc(); drive_data(1'b0, '0);
        @(negedge clk);
        check("both_c1_inst_addr_ok", inst_if.addr_ok, 1'b1);
        check("both_c1_mem_addr", mem_if.addr, 32'h1000);
        next_cyc(); drive_inst(1'b0, '0); drive_mem(1'b0, 1'b1, 32'hAAAA);
        @(negedge clk);
        check("both_r0_data_data_ok", data_if.data_ok, 1'b1);
        check("both_r0_inst_data_ok", inst_if.data_ok, 1'b0);
        check("both_r0_rdata", data_if.rdata, 32'hAAAA);
        next_cyc(); drive_mem(1'b0, 1'b1, 32'hBBBB);
        @(negedge clk);
        check("both_r1_inst_data_ok", inst_if.data_ok, 1'b1);
        check("both_r1_data_data_ok", data_if.data_ok, 1'b0);
        check("both_r1_rdata", inst_if.rdata, 32'hBBBB);
        next_cyc();

        // Slave stalls an inst request; a late data request must wait behind it
        do_reset();
        drive_inst(1'b1, 32'h3000); drive_mem(1'b0, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) drive_data(1'b1, 32'h3800);
            if (k == 3) drive_mem(1'b1, 1'b0, '0);
            @(negedge clk);
            check($sformatf("hold%0d_mem_req", k), mem_if.req, 1'b1);
            check($sformatf("hold%0d_mem_addr", k), mem_if.addr, 32'h3000);
            check($sformatf("hold%0d_inst_addr_ok", k), inst_if.addr_ok, (k == 3));
            check($sformatf("hold%0d_data_addr_ok", k), data_if.addr_ok, 1'b0);
            next_cyc();
        end
        drive_inst(1'b0, '0);
        @(negedge clk);
        check("hold_after_data_addr_ok", data_if.addr_ok, 1'b1);
        check("hold_after_mem_addr", mem_if.addr, 32'h3800);
        next_cyc();

        // Starvation guard: inst must win on the ninth contested cycle
        do_reset();
        drive_inst(1'b1, 32'h4000); drive_data(1'b1, 32'h5000);
        found = -1;
        for (int k = 0; k < 20 && found < 0; k++) begin
            drive_mem(1'b1, (k > 0), 32'h0);
            @(negedge clk);
            if (inst_if.addr_ok) found = k;
            next_cyc();
        end
        check("starve_inst_win_cycle", found, 8);
        drive_mem(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        check("starve_after_data_addr_ok", data_if.addr_ok, 1'b1);
        check("starve_cnt_cleared", dut.starve_cnt, 0);
        next_cyc();

        // FIFO full blocks new grants until a response frees a slot
        do_reset();
        drive_data(1'b1, 32'h6000); drive_mem(1'b1, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("full_fill%0d_addr_ok", k), data_if.addr_ok, 1'b1);
            next_cyc();
        end
        @(negedge clk);
        check("full_mem_req_blocked", mem_if.req, 1'b0);
        next_cyc(); drive_mem(1'b1, 1'b1, 32'hD0D0);
        @(negedge clk);
        check("full_pop_mem_req", mem_if.req, 1'b0);
        check("full_pop_data_ok", data_if.data_ok, 1'b1);
        check("full_pop_rdata", data_if.rdata, 32'hD0D0);
        next_cyc(); drive_mem(1'b1, 1'b1, 32'hD1D1);
        @(negedge clk);
        check("full_pushpop_addr_ok", data_if.addr_ok, 1'b1);
        check("full_pushpop_data_ok", data_if.data_ok, 1'b1);
        next_cyc(); drive_data(1'b0, '0); drive_mem(1'b0, 1'b0, '0);
        @(negedge clk);
        check("full_count_after", dut.u_fifo.count, 3);
        next_cyc();

        // Interleaved tags route responses back in order
        do_reset();
        tags[0] = 0; tags[1] = 1; tags[2] = 1; tags[3] = 0;
        resp[0] = 32'hA; resp[1] = 32'hB; resp[2] = 32'hC; resp[3] = 32'hD;
        for (int t = 0; t < 4; t++) begin
            drive_inst(tags[t] == 0, 32'h100 + t); drive_data(tags[t] == 1, 32'h200 + t);
            drive_mem(1'b1, 1'b0, '0);
            @(negedge clk);
            check($sformatf("il_req%0d_addr_ok", t),
                  (tags[t] == 0) ? inst_if.addr_ok : data_if.addr_ok, 1'b1);
            next_cyc();
        end
        drive_inst(1'b0, '0); drive_data(1'b0, '0);
        for (int t = 0; t < 4; t++) begin
            drive_mem(1'b0, 1'b1, resp[t]);
            @(negedge clk);
            check($sformatf("il_rsp%0d_inst_data_ok", t), inst_if.data_ok, (tags[t] == 0));
            check($sformatf("il_rsp%0d_data_data_ok", t), data_if.data_ok, (tags[t] == 1));
            check($sformatf("il_rsp%0d_rdata", t),
                  (tags[t] == 0) ? inst_if.rdata : data_if.rdata, resp[t]);
            next_cyc();
        end
        drive_mem(1'b0, 1'b0, '0);

        // Reset while holding a data request with two outstanding
        do_reset();
        drive_inst(1'b1, 32'h700); drive_mem(1'b1, 1'b0, '0);
        next_cyc(); next_cyc();
        drive_inst(1'b0, '0); drive_data(1'b1, 32'h7000); drive_mem(1'b0, 1'b0, '0);
        @(negedge clk);
        check("rstmid_pre_mem_req", mem_if.req, 1'b1);
        next_cyc();
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_state_hold_d", dut.state, HOLD_D);
        next_cyc();
        reset = 1'b0; drive_data(1'b0, '0);
        @(negedge clk);
        check("rstmid_mem_req", mem_if.req, 1'b0);
        check("rstmid_fifo_empty", dut.u_fifo.empty, 1'b1);
        check("rstmid_state_idle", dut.state, IDLE);
        next_cyc();

        // Randomized run against a queue-based model
        do_reset();
        q.delete(); lock = -1; starve = 0;
        for (int c = 0; c < 400; c++) begin
            if (!inst_if.req || inst_if.addr_ok) begin
                drive_inst($urandom_range(0, 1) == 1, $urandom);
                inst_if.wr = 1'($urandom_range(0, 1)); inst_if.wdata = $urandom;
            end
            if (!data_if.req || data_if.addr_ok) begin
                drive_data($urandom_range(0, 3) != 0, $urandom);
                data_if.wr = 1'($urandom_range(0, 1)); data_if.wdata = $urandom;
            end
            drive_mem($urandom_range(0, 3) != 0, (q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom);
            @(negedge clk);
            exp_req = 1'b0; exp_sel = 0;
            if (lock >= 0) begin
                exp_req = 1'b1; exp_sel = lock;
            end else if (q.size() < MAXO) begin
                if (data_if.req && !(starve == LIMIT && inst_if.req)) begin
                    exp_req = 1'b1; exp_sel = 1;
                end else if (inst_if.req) begin
                    exp_req = 1'b1; exp_sel = 0;
                end
            end
            acc = exp_req && mem_if.addr_ok;
            pop = mem_if.data_ok && (q.size() > 0);
            check("rnd_mem_req", mem_if.req, exp_req);
            if (exp_req) begin
                check("rnd_mem_addr", mem_if.addr, (exp_sel == 1) ? data_if.addr : inst_if.addr);
                check("rnd_mem_wdata", mem_if.wdata, (exp_sel == 1) ? data_if.wdata : inst_if.wdata);
            end
            check("rnd_inst_addr_ok", inst_if.addr_ok, acc && exp_sel == 0);
            check("rnd_data_addr_ok", data_if.addr_ok, acc && exp_sel == 1);
            check("rnd_inst_data_ok", inst_if.data_ok, pop && q[0] == 0);
            check("rnd_data_data_ok", data_if.data_ok, pop && q[0] == 1);
            if (pop) check("rnd_rdata", (q[0] == 1) ? data_if.rdata : inst_if.rdata, mem_if.rdata);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(exp_sel);
            lock = (exp_req && !acc) ? exp_sel : -1;
            if (!inst_if.req || (acc && exp_sel == 0)) starve = 0;
            else if (acc && exp_sel == 1 && starve < LIMIT) starve++;
            next_cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
